vrf_port_arbiter: RTL and testbench
===================================

# vrf_port_arbiter

- Request arbiter directly upstream of the single-port vector register file RAM.
- Merges two operand-read ports and one writeback port onto the RAM's single req/we/addr/wdata interface, one access per cycle.
- Returns read data with a one-cycle-delayed valid strobe to the port that issued the read.
- Sits between the vector issue/writeback logic and the register-file RAM instance.

## Interface
Parameters:
- Width, 128, data width of one vector register (RAM word).
- Depth, 32, number of vector registers; AW = $clog2(Depth).
- MaxWrStreak, 4, max consecutive write grants while a read waits (guard feature only).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- rd0_req_i  in  1  read request, port 0.
- rd0_addr_i  in  AW  read address, port 0.
- rd0_gnt_o  out  1  request accepted this cycle, port 0.
- rd0_rvalid_o  out  1  rd0_rdata_o valid this cycle.
- rd0_rdata_o  out  Width  read data, port 0.
- rd1_req_i, rd1_addr_i, rd1_gnt_o, rd1_rvalid_o, rd1_rdata_o: same as port 0, for port 1.
- wr_req_i  in  1  write request.
- wr_addr_i  in  AW  write address.
- wr_wdata_i  in  Width  write data.
- wr_gnt_o  out  1  write accepted this cycle.
- mem_req_o  out  1  RAM request.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  AW  RAM address.
- mem_wdata_o  out  Width  RAM write data.
- mem_rdata_i  in  Width  RAM read data; valid the cycle after a read request.

## Operation
- Handshake is req/gnt:
  - A requester holds req and address/data stable until gnt is high.
  - The transfer occurs in the cycle where req && gnt.
  - Dropping req before gnt is illegal.
- At most one gnt is high per cycle. mem_req_o = OR of all gnts.
- mem_we_o is 1 only for a write grant. mem_addr_o and mem_wdata_o follow the winner. When there is no grant, mem_addr_o and mem_wdata_o = 0.
- Priority:
  - Write beats reads (writeback must not stall).
  - Between reads: round-robin. Pointer rr (1 bit, reset 0) names the preferred read port.
  - When a read is granted, rr becomes the other port.
  - rr is unchanged on write grants or idle cycles.
- Read return:
  - Registers rv_q[1:0] hold the grant of the previous cycle. rdN_rvalid_o = rv_q[N].
  - rdN_rdata_o = mem_rdata_i while rdN_rvalid_o is high, else 0.
- Write streak counter ws (width $clog2(MaxWrStreak+1), reset 0):
  - Increments on a write grant while any rd req is pending; saturates at MaxWrStreak.
  - Clears on any read grant or when no read is pending.
  - It is observable only through the guard feature.
- Reset mid-operation: all state returns to reset values immediately. Any rvalid due next cycle is dropped; requesters must re-issue.

## Timing
- gnt and mem_* are combinational from req inputs and registered state, in the same cycle.
- Read latency: gnt in cycle t, rvalid and rdata in cycle t+1.
- Back-to-back reads give one rvalid per cycle.
- A write in t to address A followed by a read of A granted in t+1 returns the new data in t+2.
- Reset values: rd0/rd1_gnt_o=0, rd0/rd1_rvalid_o=0, rd0/rd1_rdata_o=0, wr_gnt_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0. While rst_ni is low, all outputs are 0 regardless of req inputs.
- Simultaneous rd0+rd1+wr: wr granted. Simultaneous rd0+rd1 without wr: port rr granted, the other next cycle.

## Configuration
- Macro VRF_ARB_STARVE_GUARD_EN:
  - Defined: when ws == MaxWrStreak and a read is pending, the next arbitration gives reads priority over write for one grant (round-robin among reads). wr_gnt_o is 0 that cycle and ws clears.
  - Undefined: ws logic is omitted. Write always has strict priority, so reads may starve under continuous writes.

## Test plan
- Single read: rd0_req, addr=3, RAM holds 0x33..33 → rd0_gnt_o=1, mem_req_o=1, mem_we_o=0, mem_addr_o=3 in t; rd0_rvalid_o=1 and rd0_rdata_o=0x33..33 in t+1; rd1_rvalid_o=0.
- Write then read: wr addr=5, data 0xA5..A5 in t; rd1 read addr=5 in t+1 → rd1_rdata_o=0xA5..A5 in t+2.
- Contention: rd0, rd1 and wr all held from t with rr=0 → grants wr(t), rd0(t+1), rd1(t+2); rvalids at t+2 (port 0) and t+3 (port 1).
- Round-robin: rd0 and rd1 held continuously, no write → grants alternate 0,1,0,1; rr toggles each cycle.
- Guard (macro defined, MaxWrStreak=4): wr held continuously, rd0 held → four wr grants, then rd0 granted in the 5th cycle, then wr resumes. Macro undefined → rd0 never granted while wr is held.
- Reset mid-read: assert rst_ni=0 one cycle after rd0 grant → rd0_rvalid_o=0, all outputs 0, rr=0 after release.

Source files
------------

// File: rtl/vrf_port_arbiter.sv
// ---------------------------------------------------------------------------
// vrf_port_arbiter
//
// Purpose: merges two vector operand-read ports and one writeback port onto
// the single-port vector register file RAM. At most one access is granted
// per cycle. Read data returns to the issuing port one cycle after its grant.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   rd0_* / rd1_*                  read ports: req/addr in, gnt/rvalid/rdata out
//   wr_*                           write port: req/addr/wdata in, gnt out
//   mem_req_o/we_o/addr_o/wdata_o  RAM request side (combinational)
//   mem_rdata_i                    RAM read data, valid the cycle after a read
//
// Handshake (all three request ports): a requester raises req with its
// address (and data for writes) and holds them stable until gnt is seen
// high; the transfer happens in the cycle where req && gnt. Dropping req
// before gnt is not allowed.
//
// Optional feature: define VRF_ARB_STARVE_GUARD_EN to enable the write-streak
// guard. After MaxWrStreak consecutive write grants with a read waiting, one
// read is granted ahead of the write. Without the macro, writes always win.
// ---------------------------------------------------------------------------
module vrf_port_arbiter #(
    parameter int Width       = 128,
    parameter int Depth       = 32,
    parameter int MaxWrStreak = 4,
    parameter int AW          = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rd0_req_i,
    input  logic [AW-1:0]    rd0_addr_i,
    output logic             rd0_gnt_o,
    output logic             rd0_rvalid_o,
    output logic [Width-1:0] rd0_rdata_o,
    input  logic             rd1_req_i,
    input  logic [AW-1:0]    rd1_addr_i,
    output logic             rd1_gnt_o,
    output logic             rd1_rvalid_o,
    output logic [Width-1:0] rd1_rdata_o,
    input  logic             wr_req_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [Width-1:0] wr_wdata_i,
    output logic             wr_gnt_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    input  logic [Width-1:0] mem_rdata_i
);

    // rr_q names the preferred read port when both reads contend.
    logic       rr_q, rr_d;
    // rv_q remembers which read port was granted last cycle.
    logic [1:0] rv_q, rv_d;

    logic rd_pend;
    logic force_rd;
    logic rd0_gnt, rd1_gnt, wr_gnt;

    assign rd_pend = rd0_req_i | rd1_req_i;

`ifdef VRF_ARB_STARVE_GUARD_EN
    localparam int              WsW   = $clog2(MaxWrStreak + 1);
    localparam logic [WsW-1:0]  WsMax = WsW'(MaxWrStreak);

    logic [WsW-1:0] ws_q, ws_d;

    // A full streak with a read waiting hands the next grant to the reads.
    assign force_rd = rd_pend && (ws_q == WsMax);

    always_comb begin
        ws_d = ws_q;
        if (rd0_gnt || rd1_gnt || !rd_pend) begin
            ws_d = '0;
        end else if (wr_gnt && (ws_q != WsMax)) begin
            ws_d = ws_q + WsW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ws_q <= '0;
        end else begin
            ws_q <= ws_d;
        end
    end
`else
    // The streak limit has no effect when writes always have priority.
    logic [31:0] unused_max_wr_streak;
    assign unused_max_wr_streak = MaxWrStreak;
    assign force_rd             = 1'b0;
`endif

    // Grant selection. Grants are forced low while reset is asserted so that
    // every output is quiet regardless of the request inputs.
    always_comb begin
        wr_gnt  = 1'b0;
        rd0_gnt = 1'b0;
        rd1_gnt = 1'b0;
        if (rst_ni) begin
            if (wr_req_i && !force_rd) begin
                wr_gnt = 1'b1;
            end else if (rd0_req_i && rd1_req_i) begin
                rd0_gnt = ~rr_q;
                rd1_gnt = rr_q;
            end else begin
                rd0_gnt = rd0_req_i;
                rd1_gnt = rd1_req_i;
            end
        end
    end

    // Winner drives the RAM; idle cycles present zeros.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (wr_gnt) begin
            mem_addr_o  = wr_addr_i;
            mem_wdata_o = wr_wdata_i;
        end else if (rd0_gnt) begin
            mem_addr_o = rd0_addr_i;
        end else if (rd1_gnt) begin
            mem_addr_o = rd1_addr_i;
        end
    end

    // The preference moves to the port that was not just served; write
    // grants and idle cycles leave it alone.
    always_comb begin
        rr_d = rr_q;
        if (rd0_gnt) begin
            rr_d = 1'b1;
        end else if (rd1_gnt) begin
            rr_d = 1'b0;
        end
    end

    assign rv_d = {rd1_gnt, rd0_gnt};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 1'b0;
            rv_q <= 2'b00;
        end else begin
            rr_q <= rr_d;
            rv_q <= rv_d;
        end
    end

    assign rd0_gnt_o = rd0_gnt;
    assign rd1_gnt_o = rd1_gnt;
    assign wr_gnt_o  = wr_gnt;
    assign mem_req_o = rd0_gnt | rd1_gnt | wr_gnt;
    assign mem_we_o  = wr_gnt;

    assign rd0_rvalid_o = rv_q[0];
    assign rd1_rvalid_o = rv_q[1];
    assign rd0_rdata_o  = rv_q[0] ? mem_rdata_i : '0;
    assign rd1_rdata_o  = rv_q[1] ? mem_rdata_i : '0;

endmodule

// File: tb/tb_vrf_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vrf_port_arbiter
//
// Bench for vrf_port_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the arbitration rules.
// A simple RAM model sits on the mem_* side and returns read data one cycle
// later (garbage on cycles without a read).
// ---------------------------------------------------------------------------
module tb_vrf_port_arbiter;

    localparam int W      = 128;
    localparam int DEPTH  = 32;
    localparam int MAX_WS = 4;
    localparam int AW     = $clog2(DEPTH);

`ifdef VRF_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          rd0_req, rd1_req, wr_req;
    logic [AW-1:0] rd0_addr, rd1_addr, wr_addr;
    logic [W-1:0]  wr_wdata;
    logic          rd0_gnt, rd1_gnt, wr_gnt;
    logic          rd0_rvalid, rd1_rvalid;
    logic [W-1:0]  rd0_rdata, rd1_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata, mem_rdata;

    vrf_port_arbiter #(
        .Width(W), .Depth(DEPTH), .MaxWrStreak(MAX_WS)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rd0_req_i   (rd0_req),
        .rd0_addr_i  (rd0_addr),
        .rd0_gnt_o   (rd0_gnt),
        .rd0_rvalid_o(rd0_rvalid),
        .rd0_rdata_o (rd0_rdata),
        .rd1_req_i   (rd1_req),
        .rd1_addr_i  (rd1_addr),
        .rd1_gnt_o   (rd1_gnt),
        .rd1_rvalid_o(rd1_rvalid),
        .rd1_rdata_o (rd1_rdata),
        .wr_req_i    (wr_req),
        .wr_addr_i   (wr_addr),
        .wr_wdata_i  (wr_wdata),
        .wr_gnt_o    (wr_gnt),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // ---------------- RAM model on the mem_* side ----------------
    logic [W-1:0] ram [DEPTH];

    function automatic logic [W-1:0] rand_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        if (mem_req && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            mem_rdata     <= rand_w();
        end else if (mem_req) begin
            mem_rdata <= ram[mem_addr];
        end else begin
            mem_rdata <= rand_w();
        end
    end

    // ---------------- scoreboard state ----------------
    int n_vec;
    int n_err;
    logic [W-1:0] ref_mem [DEPTH];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rd0_req  = 1'b0; rd0_addr = '0;
        rd1_req  = 1'b0; rd1_addr = '0;
        wr_req   = 1'b0; wr_addr  = '0; wr_wdata = '0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        rd0_req  = 1'b1; rd0_addr = 5'd7;
        rd1_req  = 1'b1; rd1_addr = 5'd9;
        wr_req   = 1'b1; wr_addr  = 5'd3; wr_wdata = rand_w();
        repeat (2) begin
            @(negedge clk);
            #1;
            n_vec++;
            if ({rd0_gnt, rd1_gnt, wr_gnt, mem_req, mem_we, rd0_rvalid, rd1_rvalid} !== 7'b0) begin
                $display("FAIL reset_ctrl: got %b expected 0000000",
                         {rd0_gnt, rd1_gnt, wr_gnt, mem_req, mem_we, rd0_rvalid, rd1_rvalid});
                n_err++;
            end
            n_vec++;
            if ({mem_addr, mem_wdata, rd0_rdata, rd1_rdata} !== '0) begin
                $display("FAIL reset_data: addr %h wdata %h rdata0 %h rdata1 %h expected all 0",
                         mem_addr, mem_wdata, rd0_rdata, rd1_rdata);
                n_err++;
            end
        end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        logic [W-1:0] pat;
        pat = {16{8'h33}};
        reset_dut();
        ram[3] = pat;
        @(negedge clk);
        rd0_req = 1'b1; rd0_addr = 5'd3;
        #1;
        n_vec++;
        if ({rd0_gnt, rd1_gnt, wr_gnt, mem_req, mem_we} !== 5'b10010 || mem_addr !== 5'd3) begin
            $display("FAIL single_read_gnt: gnt/req/we %b addr %0d expected 10010 addr 3",
                     {rd0_gnt, rd1_gnt, wr_gnt, mem_req, mem_we}, mem_addr);
            n_err++;
        end
        @(negedge clk);
        rd0_req = 1'b0;
        #1;
        n_vec++;
        if (rd0_rvalid !== 1'b1 || rd1_rvalid !== 1'b0 || rd0_rdata !== pat) begin
            $display("FAIL single_read_ret: rv0 %b rv1 %b rdata %h expected 1 0 %h",
                     rd0_rvalid, rd1_rvalid, rd0_rdata, pat);
            n_err++;
        end
    endtask

    task automatic test_write_then_read();
        logic [W-1:0] pat;
        pat = {16{8'hA5}};
        reset_dut();
        ram[5] = '0;
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 5'd5; wr_wdata = pat;
        #1;
        n_vec++;
        if (wr_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'd5 || mem_wdata !== pat) begin
            $display("FAIL wr_gnt: gnt %b we %b addr %0d wdata %h expected 1 1 5 %h",
                     wr_gnt, mem_we, mem_addr, mem_wdata, pat);
            n_err++;
        end
        @(negedge clk);
        wr_req = 1'b0; wr_wdata = '0;
        rd1_req = 1'b1; rd1_addr = 5'd5;
        #1;
        n_vec++;
        if (rd1_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd5 || mem_wdata !== '0) begin
            $display("FAIL rd1_gnt_after_wr: gnt %b we %b addr %0d wdata %h expected 1 0 5 0",
                     rd1_gnt, mem_we, mem_addr, mem_wdata);
            n_err++;
        end
        @(negedge clk);
        rd1_req = 1'b0;
        #1;
        n_vec++;
        if (rd1_rvalid !== 1'b1 || rd0_rvalid !== 1'b0 || rd1_rdata !== pat || rd0_rdata !== '0) begin
            $display("FAIL wr_rd_data: rv1 %b rv0 %b rdata1 %h rdata0 %h expected 1 0 %h 0",
                     rd1_rvalid, rd0_rvalid, rd1_rdata, rd0_rdata, pat);
            n_err++;
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] d1, d2;
        d1 = rand_w();
        d2 = rand_w();
        reset_dut();
        ram[1] = d1;
        ram[2] = d2;
        @(negedge clk);
        rd0_req = 1'b1; rd0_addr = 5'd1;
        rd1_req = 1'b1; rd1_addr = 5'd2;
        wr_req  = 1'b1; wr_addr  = 5'd7; wr_wdata = rand_w();
        #1;
        n_vec++;
        if ({wr_gnt, rd0_gnt, rd1_gnt} !== 3'b100) begin
            $display("FAIL contend_t0: wr/rd0/rd1 gnt %b expected 100", {wr_gnt, rd0_gnt, rd1_gnt});
            n_err++;
        end
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        n_vec++;
        if ({wr_gnt, rd0_gnt, rd1_gnt} !== 3'b010 || mem_addr !== 5'd1) begin
            $display("FAIL contend_t1: gnt %b addr %0d expected 010 addr 1",
                     {wr_gnt, rd0_gnt, rd1_gnt}, mem_addr);
            n_err++;
        end
        @(negedge clk);
        rd0_req = 1'b0;
        #1;
        n_vec++;
        if ({wr_gnt, rd0_gnt, rd1_gnt} !== 3'b001 || rd0_rvalid !== 1'b1 || rd0_rdata !== d1) begin
            $display("FAIL contend_t2: gnt %b rv0 %b rdata0 %h expected 001 1 %h",
                     {wr_gnt, rd0_gnt, rd1_gnt}, rd0_rvalid, rd0_rdata, d1);
            n_err++;
        end
        @(negedge clk);
        rd1_req = 1'b0;
        #1;
        n_vec++;
        if (rd1_rvalid !== 1'b1 || rd0_rvalid !== 1'b0 || rd1_rdata !== d2 || mem_req !== 1'b0) begin
            $display("FAIL contend_t3: rv1 %b rv0 %b rdata1 %h mem_req %b expected 1 0 %h 0",
                     rd1_rvalid, rd0_rvalid, rd1_rdata, mem_req, d2);
            n_err++;
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        reset_dut();
        @(negedge clk);
        rd0_req = 1'b1; rd0_addr = 5'd10;
        rd1_req = 1'b1; rd1_addr = 5'd11;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_vec++;
            if ({rd1_gnt, rd0_gnt} !== exp_g) begin
                $display("FAIL round_robin[%0d]: rd1/rd0 gnt %b expected %b", i, {rd1_gnt, rd0_gnt}, exp_g);
                n_err++;
            end
            if (i > 0) begin
                n_vec++;
                if ({rd1_rvalid, rd0_rvalid} !== ~exp_g) begin
                    $display("FAIL rr_rvalid[%0d]: rv1/rv0 %b expected %b", i, {rd1_rvalid, rd0_rvalid}, ~exp_g);
                    n_err++;
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_guard();
        logic exp_rd;
        reset_dut();
        @(negedge clk);
        rd0_req = 1'b1; rd0_addr = 5'd4;
        wr_req  = 1'b1; wr_addr  = 5'd20; wr_wdata = rand_w();
        for (int i = 0; i < 12; i++) begin
            #1;
            exp_rd = GUARD && (i % (MAX_WS + 1) == MAX_WS);
            n_vec++;
            if ({wr_gnt, rd0_gnt} !== {~exp_rd, exp_rd}) begin
                $display("FAIL guard[%0d]: wr/rd0 gnt %b expected %b", i, {wr_gnt, rd0_gnt}, {~exp_rd, exp_rd});
                n_err++;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        reset_dut();
        @(negedge clk);
        rd0_req = 1'b1; rd0_addr = 5'd3;
        #1;
        n_vec++;
        if (rd0_gnt !== 1'b1) begin
            $display("FAIL midrst_gnt: rd0_gnt %b expected 1", rd0_gnt);
            n_err++;
        end
        @(negedge clk);
        rst_n   = 1'b0;
        rd1_req = 1'b1; rd1_addr = 5'd6;
        wr_req  = 1'b1; wr_addr  = 5'd8; wr_wdata = rand_w();
        #1;
        n_vec++;
        if ({rd0_rvalid, rd1_rvalid, rd0_gnt, rd1_gnt, wr_gnt, mem_req, mem_we} !== 7'b0 ||
            {rd0_rdata, rd1_rdata, mem_addr, mem_wdata} !== '0) begin
            $display("FAIL midrst_outputs: ctrl %b rdata0 %h addr %0d expected all 0",
                     {rd0_rvalid, rd1_rvalid, rd0_gnt, rd1_gnt, wr_gnt, mem_req, mem_we},
                     rd0_rdata, mem_addr);
            n_err++;
        end
        @(negedge clk);
        rst_n  = 1'b1;
        wr_req = 1'b0;
        #1;
        // The pre-reset grant to port 0 moved the preference; reset restores it.
        n_vec++;
        if ({rd1_gnt, rd0_gnt} !== 2'b01 || rd0_rvalid !== 1'b0) begin
            $display("FAIL midrst_rr: rd1/rd0 gnt %b rv0 %b expected 01 0", {rd1_gnt, rd0_gnt}, rd0_rvalid);
            n_err++;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // Randomized run against a reference model of the arbitration rules.
    task automatic test_random();
        int  pref;
        int  streak;
        int  win;
        bit  g0, g1, gw;
        bit  exp_rv;
        logic [W-1:0] exp_d;
        logic [AW-1:0] exp_addr;
        logic [W-1:0]  exp_wdata;

        reset_dut();
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = ram[a];
        exp_q0.delete();
        exp_q1.delete();
        pref   = 0;
        streak = 0;
        g0 = 1'b0; g1 = 1'b0; gw = 1'b0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (!rd0_req || g0) begin
                rd0_req  = ($urandom_range(0, 99) < 45);
                rd0_addr = AW'($urandom_range(0, DEPTH - 1));
            end
            if (!rd1_req || g1) begin
                rd1_req  = ($urandom_range(0, 99) < 45);
                rd1_addr = AW'($urandom_range(0, DEPTH - 1));
            end
            if (!wr_req || gw) begin
                wr_req   = ($urandom_range(0, 99) < 60);
                wr_addr  = AW'($urandom_range(0, DEPTH - 1));
                wr_wdata = rand_w();
            end
            #1;

            // Expected winner: 2 = write, 0/1 = read port, -1 = none.
            if (wr_req && !(GUARD && streak >= MAX_WS && (rd0_req || rd1_req))) win = 2;
            else if (rd0_req && rd1_req) win = pref;
            else if (rd0_req) win = 0;
            else if (rd1_req) win = 1;
            else win = -1;

            exp_addr  = (win == 2) ? wr_addr : (win == 0) ? rd0_addr : (win == 1) ? rd1_addr : '0;
            exp_wdata = (win == 2) ? wr_wdata : '0;

            n_vec++;
            if ({wr_gnt, rd1_gnt, rd0_gnt, mem_req, mem_we} !==
                {win == 2, win == 1, win == 0, win != -1, win == 2}) begin
                $display("FAIL rand_gnt[%0d]: wr/rd1/rd0/req/we %b expected %b", cyc,
                         {wr_gnt, rd1_gnt, rd0_gnt, mem_req, mem_we},
                         {win == 2, win == 1, win == 0, win != -1, win == 2});
                n_err++;
            end
            n_vec++;
            if (mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
                $display("FAIL rand_mem[%0d]: addr %0d wdata %h expected %0d %h", cyc,
                         mem_addr, mem_wdata, exp_addr, exp_wdata);
                n_err++;
            end

            exp_rv = (exp_q0.size() > 0);
            exp_d  = exp_rv ? exp_q0.pop_front() : '0;
            n_vec++;
            if (rd0_rvalid !== exp_rv || rd0_rdata !== exp_d) begin
                $display("FAIL rand_rd0[%0d]: rvalid %b rdata %h expected %b %h", cyc,
                         rd0_rvalid, rd0_rdata, exp_rv, exp_d);
                n_err++;
            end
            exp_rv = (exp_q1.size() > 0);
            exp_d  = exp_rv ? exp_q1.pop_front() : '0;
            n_vec++;
            if (rd1_rvalid !== exp_rv || rd1_rdata !== exp_d) begin
                $display("FAIL rand_rd1[%0d]: rvalid %b rdata %h expected %b %h", cyc,
                         rd1_rvalid, rd1_rdata, exp_rv, exp_d);
                n_err++;
            end

            // Advance the model to the state after this clock edge.
            g0 = (win == 0); g1 = (win == 1); gw = (win == 2);
            if (win == 0) begin
                exp_q0.push_back(ref_mem[rd0_addr]);
                pref = 1;
            end else if (win == 1) begin
                exp_q1.push_back(ref_mem[rd1_addr]);
                pref = 0;
            end else if (win == 2) begin
                ref_mem[wr_addr] = wr_wdata;
            end
            if (win == 0 || win == 1 || !(rd0_req || rd1_req)) streak = 0;
            else if (win == 2 && streak < MAX_WS) streak++;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // ---------------- sequencer + report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) ram[a] = rand_w();

        test_reset();
        test_single_read();
        test_write_then_read();
        test_contention();
        test_round_robin();
        test_guard();
        test_reset_mid_read();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
